// File: rtl/gate_tree_compare.sv
// rtl/gate_tree_compare.sv - N-input reduction computed flat and as a registered 2-input tree, cross-checked per sample
module gate_tree_compare #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic [1:0]       op,
  input  logic             fault_inj,
  input  logic             clear,
  output logic             out_valid,
  output logic             out_flat,
  output logic             out_tree,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int L     = $clog2(N);
  // One spare bit so the odd-count pass-through never indexes past the vector.
  localparam int W     = N + 1;
  localparam int PAIRS = (N + 1) / 2;

  function automatic int nodes(input int k);
    return (N + (1 << k) - 1) >> k;
  endfunction

  function automatic logic base_gate(input logic a, input logic b, input logic [1:0] f);
    case (f)
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic flat_reduce(input logic [N-1:0] d, input logic [1:0] f);
    case (f)
      2'b00:   return |d;
      2'b01:   return &d;
      2'b10:   return ^d;
      default: return ~|d;
    endcase
  endfunction

  logic [W-1:0]     tree_q  [L+1];
  logic [W-1:0]     tree_d  [L+1];
  logic [1:0]       op_q    [L+1];
  logic [1:0]       op_d    [L+1];
  logic [L:0]       vld_q, vld_d;
  logic [L:0]       fault_q, fault_d;
  logic [L:1]       flat_q, flat_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic             err_q, err_d;

  always_comb begin
    tree_d[0]  = tree_q[0];
    op_d[0]    = op_q[0];
    fault_d[0] = fault_q[0];
    vld_d      = '0;
    fault_d[L:1] = fault_q[L-1:0];
    vld_d[0]   = in_valid;
    if (in_valid) begin
      tree_d[0]  = {1'b0, in_data};
      op_d[0]    = op;
      fault_d[0] = fault_inj;
    end
    for (int k = 1; k <= L; k++) begin
      tree_d[k] = '0;
      for (int i = 0; i < PAIRS; i++) begin
        if (i < nodes(k)) begin
          if (2 * i + 1 < nodes(k - 1))
            tree_d[k][i] = base_gate(tree_q[k-1][2*i], tree_q[k-1][2*i+1], op_q[k-1]);
          else
            tree_d[k][i] = tree_q[k-1][2*i];
        end
      end
      op_d[k]  = op_q[k-1];
      vld_d[k] = vld_q[k-1];
    end
    flat_d    = flat_q;
    flat_d[1] = flat_reduce(tree_q[0][N-1:0], op_q[0]);
    for (int k = 2; k <= L; k++) flat_d[k] = flat_q[k-1];
  end

  assign out_valid = vld_q[L];
  assign out_flat  = flat_q[L];
  assign out_tree  = tree_q[L][0] ^ (op_q[L] == 2'b11) ^ fault_q[L];
  assign mismatch  = out_valid & (out_flat ^ out_tree);

  // Clear wins over any increment or sticky set landing on the same edge.
  always_comb begin
    mismatch_cnt_d = mismatch_cnt_q;
    sample_cnt_d   = sample_cnt_q;
    err_d          = err_q;
    if (clear) begin
      mismatch_cnt_d = '0;
      sample_cnt_d   = '0;
      err_d          = 1'b0;
    end else begin
      if (out_valid) sample_cnt_d = sample_cnt_q + 1'b1;
      if (mismatch) begin
        err_d = 1'b1;
        if (mismatch_cnt_q != {CNT_W{1'b1}}) mismatch_cnt_d = mismatch_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= L; k++) begin
        tree_q[k] <= '0;
        op_q[k]   <= '0;
      end
      vld_q          <= '0;
      fault_q        <= '0;
      flat_q         <= '0;
      mismatch_cnt_q <= '0;
      sample_cnt_q   <= '0;
      err_q          <= 1'b0;
    end else begin
      tree_q         <= tree_d;
      op_q           <= op_d;
      vld_q          <= vld_d;
      fault_q        <= fault_d;
      flat_q         <= flat_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
      err_q          <= err_d;
    end
  end

  assign err_sticky   = err_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign sample_cnt   = sample_cnt_q;

endmodule

// File: doc/gate_tree_compare.md
# gate_tree_compare

Parametrised, pipelined N-input reduction gate that computes the same logic function two ways, as a flat reduction and as a registered tree of 2-input gates, and checks that the two agree on every sample. It is the next generation of the 3-input flat-versus-2-input-tree gate comparison in the basic-gates library. It generalises that comparison in input count and gate function, and adds a valid pipeline, runtime operation select, fault injection, and mismatch accounting. It sits in the gate library as a self-checking structural reference and a bench target for tree-decomposition logic.

## Interface
- `N`, 8: number of data inputs; legal range 2..64.
- `CNT_W`, 16: width of the mismatch and sample counters.
- Derived `L` = ceil(log2 N): number of tree levels; not overridable.

- `clk`, input, 1: single clock; rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: the sample on `in_data`, `op` and `fault_inj` is accepted this cycle.
- `in_data`, input, N: operand bits.
- `op`, input, 2: function select. 00 OR, 01 AND, 10 XOR, 11 NOR.
- `fault_inj`, input, 1: invert the tree result of this sample (verification hook).
- `clear`, input, 1: zero the counters and the sticky error flag.
- `out_valid`, output, 1: result pair is valid this cycle.
- `out_flat`, output, 1: flat-reduction result.
- `out_tree`, output, 1: tree result.
- `mismatch`, output, 1: single-cycle pulse when `out_valid` is high and `out_flat` differs from `out_tree`.
- `err_sticky`, output, 1: latched high on the first mismatch.
- `mismatch_cnt`, output, CNT_W: saturating mismatch count.
- `sample_cnt`, output, CNT_W: wrapping count of valid outputs.

## Operation
- **Stage 0 (input register).** On `in_valid`, capture `in_data`, `op` and `fault_inj`. The valid bit is always registered, so an idle cycle propagates as an invalid slot.
- **Tree.** There are L registered levels. Level k pairs adjacent nodes of level k-1 with the base gate (OR for op 00 and 11, AND for 01, XOR for 10).
  - With an odd node count, the last node passes through registered, unchanged. No identity padding is used.
  - `op` and `fault_inj` travel with each sample through every level, so `op` may change on any cycle without corrupting samples already in flight.
- **Final tree value.** Invert if op=11. Then XOR with the carried `fault_inj`.
- **Flat path.** Compute the full reduction (|, &, ^, ~|) from the stage-0 register, then delay it L cycles through a shift register aligned with the tree valid pipeline.
- **Compare.** When `out_valid` is high:
  - `mismatch` = `out_flat` ^ `out_tree`.
  - `sample_cnt` increments and wraps.
  - On a mismatch, `mismatch_cnt` increments and holds at all-ones; `err_sticky` sets.
- **`clear`** zeroes `mismatch_cnt`, `sample_cnt` and `err_sticky`. It has priority over a simultaneous increment or set: the result is 0 the following cycle. It does not flush the pipeline.
- **`mismatch`** is combinational from the output registers, valid only when `out_valid`=1, and forced 0 otherwise.

## Timing
- Latency: a sample accepted at rising edge t appears with `out_valid`=1 during the cycle after edge t+L. That is L+1 registers, for example 4 cycles for N=8 and 7 cycles for N=64.
- Throughput: one sample per cycle. There is no backpressure and no ready signal.
- Reset values, one cycle after `rst` is sampled high: `out_valid`=0, `out_flat`=0, `out_tree`=0, `mismatch`=0, `err_sticky`=0, `mismatch_cnt`=0, `sample_cnt`=0. All pipeline valid bits are cleared.
- Reset mid-stream discards every in-flight sample. No `out_valid` occurs for samples accepted before reset.
- `in_valid` held at 0 produces no `out_valid` and leaves counters unchanged. Data registers may hold stale values.
- `rst` and `clear` asserted together: reset behaviour applies.
- Odd N (for example N=5, L=3): the unpaired node passes through registered, so latency is still L+1. The flat and tree results must match for all 32 inputs.

## Test plan
- **Pipeline and functions.** N=8, reset, then back-to-back samples `in_data`=8'h00 op 00, then 8'h01 op 00, 8'hFF op 01, 8'hFE op 01, 8'h07 op 10, 8'h00 op 11. Required response: `out_valid` at cycles 4..9 with `out_tree`=`out_flat` = 0,1,1,0,1,1; `mismatch` stays 0; `sample_cnt`=6.
- **Exhaustive odd width.** N=5: all 32 inputs for each of the 4 ops, one per cycle. Required response: 128 outputs, `mismatch_cnt`=0, `sample_cnt`=128, latency 4.
- **Fault injection.** N=8, `in_data`=8'h10, op 00, `fault_inj`=1. Required response at cycle 4: `out_flat`=1, `out_tree`=0, `mismatch` pulse for 1 cycle, `err_sticky`=1, `mismatch_cnt`=1.
- **Saturation and clear.** CNT_W=4: 20 consecutive fault-injected samples. Required response: `mismatch_cnt` holds at 15 and `sample_cnt` wraps to 4. Then assert `clear` on the same cycle as a mismatching output: next cycle both counters are 0 and `err_sticky`=0.
- **Reset mid-stream.** N=8: issue 3 samples, assert `rst` at cycle 2. Required response: no `out_valid` ever appears for those samples, and all outputs are 0 after reset.
- **Bubbles and op change.** N=16: alternate `in_valid` 1/0 while `op` toggles every cycle. Required response: `out_valid` pattern mirrors the input with a 5-cycle delay, and each result matches the op captured with its sample.
